multicycle_ctrl: RTL and testbench

Multicycle control FSM for the RISC-V load/store datapath; the next generation of the combinational load/store decoder. Sequences each instruction through decode, memory access with a ready/wait handshake, and register writeback. Supports every load/store width for XLEN 32 or 64, and generates byte enables. Raises faults for illegal encodings, misalignment and memory timeout. Sits between the instruction register and the data memory/register file enables.

---
 rtl/ctrl_pkg.sv | 64 ++++++
 rtl/byte_en_gen.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multicycle load/store control FSM.
package ctrl_pkg;

  // Major opcodes handled by the controller
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // funct3 width codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } fault_cause_e;

  // Load widths: ld and lwu only exist on RV64
  function automatic logic load_f3_legal(input logic [2:0] f3, input logic rv64);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      F3_D, F3_WU:                    ok = rv64;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Store widths: sd only exists on RV64
  function automatic logic store_f3_legal(input logic [2:0] f3, input logic rv64);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_D:             ok = rv64;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/byte_en_gen.sv
// Byte-lane enable and alignment check for one load/store access.
module byte_en_gen
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        size,
  input  logic [2:0]        offset,
  output logic [XLEN/8-1:0] byte_en,
  output logic              misaligned
);

  localparam int NB = XLEN / 8;

  logic [2:0]    lane_off_s;
  logic [3:0]    nbytes_s;
  logic [NB-1:0] base_s;

  // Build the unshifted lane mask, shift it to the offset and flag misalignment
  always_comb begin
    lane_off_s = (XLEN == 64) ? offset : {1'b0, offset[1:0]};
    nbytes_s   = 4'd1 << size;
    base_s     = '0;
    for (int i = 0; i < NB; i++) begin
      base_s[i] = (4'(i) < nbytes_s);
    end
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = offset[0];
      SIZE_W:  misaligned = |offset[1:0];
      SIZE_D:  misaligned = |offset;
      default: misaligned = 1'b1;
    endcase
    if (size == SIZE_D) begin
      byte_en = base_s;
    end else begin
      byte_en = base_s << lane_off_s;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle load/store control: decode, memory handshake, writeback, faults.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [2:0]        addr_lo,
  input  logic              mem_ready,
  input  logic              fault_clear,
  output logic              memread,
  output logic              memwrite,
  output logic              regwrite,
  output logic [1:0]        mem_size,
  output logic              mem_unsigned,
  output logic [XLEN/8-1:0] byte_en,
  output logic              instr_done,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam int         NB      = XLEN / 8;
  localparam logic       RV64    = (XLEN == 64);
  localparam int         CW      = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW:0] LIMIT_C = (CW + 1)'(WAIT_LIMIT);

  state_e        state_q, state_d;
  logic [6:0]    opcode_q, opcode_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;

  logic          instr_ready_q, instr_ready_d;
  logic          memread_q, memread_d;
  logic          memwrite_q, memwrite_d;
  logic          regwrite_q, regwrite_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic          mem_unsigned_q, mem_unsigned_d;
  logic [NB-1:0] byte_en_q, byte_en_d;
  logic          fault_q, fault_d;

  logic          is_load_s, is_store_s, is_mem_s, is_alu_s, f3_legal_s;
  logic          misaligned_s, timeout_s, access_s;
  logic [NB-1:0] be_s;
  logic [CW:0]   cnt_inc_s;

  // Lane mask and alignment for the captured width at the live address
  byte_en_gen #(
    .XLEN(XLEN)
  ) u_be_gen (
    .size       (funct3_q[1:0]),
    .offset     (addr_lo),
    .byte_en    (be_s),
    .misaligned (misaligned_s)
  );

  // Classify the captured instruction and evaluate the wait timeout
  always_comb begin
    is_load_s  = (opcode_q == OPC_LOAD);
    is_store_s = (opcode_q == OPC_STORE);
    is_mem_s   = is_load_s || is_store_s;
    is_alu_s   = (opcode_q == OPC_OP) || (opcode_q == OPC_OP_IMM);
    if (is_load_s) begin
      f3_legal_s = load_f3_legal(funct3_q, RV64);
    end else begin
      f3_legal_s = store_f3_legal(funct3_q, RV64);
    end
    cnt_inc_s = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    timeout_s = (WAIT_LIMIT != 0) && (cnt_inc_s == LIMIT_C);
  end

  // Next-state, capture registers, wait counter and fault cause
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          opcode_d = opcode;
          funct3_d = funct3;
          state_d  = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (is_mem_s) begin
          if (!f3_legal_s) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_ILLEGAL;
          end else if (misaligned_s) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = ST_MEM;
          end
        end else if (is_alu_s) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FAULT;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_MEM, ST_WAIT: begin
        // A completing access always beats the timeout in the same cycle
        if (mem_ready) begin
          state_d = is_load_s ? ST_WB : ST_IDLE;
        end else if (state_q == ST_MEM) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (timeout_s) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_inc_s[CW-1:0];
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        // fault_clear wins over a pending instr_valid: nothing is captured here
        if (fault_clear) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // Output values for the upcoming state, so the outputs come straight from flops
  always_comb begin
    access_s       = (state_d == ST_MEM) || (state_d == ST_WAIT);
    instr_ready_d  = (state_d == ST_IDLE);
    memread_d      = access_s && (opcode_d == OPC_LOAD);
    memwrite_d     = access_s && (opcode_d == OPC_STORE);
    mem_size_d     = access_s ? funct3_d[1:0] : 2'b00;
    mem_unsigned_d = access_s && funct3_d[2];
    regwrite_d     = (state_d == ST_WB);
    fault_d        = (state_d == ST_FAULT);
    // The lane mask is latched once on entry to MEM and held through WAIT
    if (access_s) begin
      byte_en_d = (state_q == ST_DECODE) ? be_s : byte_en_q;
    end else begin
      byte_en_d = '0;
    end
  end

  // State and output registers; reset drops every enable immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      opcode_q       <= 7'd0;
      funct3_q       <= 3'd0;
      cnt_q          <= '0;
      cause_q        <= CAUSE_NONE;
      instr_ready_q  <= 1'b1;
      memread_q      <= 1'b0;
      memwrite_q     <= 1'b0;
      regwrite_q     <= 1'b0;
      mem_size_q     <= 2'd0;
      mem_unsigned_q <= 1'b0;
      byte_en_q      <= '0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      funct3_q       <= funct3_d;
      cnt_q          <= cnt_d;
      cause_q        <= cause_d;
      instr_ready_q  <= instr_ready_d;
      memread_q      <= memread_d;
      memwrite_q     <= memwrite_d;
      regwrite_q     <= regwrite_d;
      mem_size_q     <= mem_size_d;
      mem_unsigned_q <= mem_unsigned_d;
      byte_en_q      <= byte_en_d;
      fault_q        <= fault_d;
    end
  end

  assign instr_ready  = instr_ready_q;
  assign memread      = memread_q;
  assign memwrite     = memwrite_q;
  assign regwrite     = regwrite_q;
  assign mem_size     = mem_size_q;
  assign mem_unsigned = mem_unsigned_q;
  assign byte_en      = byte_en_q;
  assign fault        = fault_q;
  assign fault_cause  = cause_q;
  // Loads retire from WB; a store retires in the access cycle that completes
  assign instr_done   = regwrite_q || (memwrite_q && mem_ready);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a retire/fault scoreboard.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  typedef struct packed {
    logic [1:0] kind;   // 0 writeback retire, 1 store retire, 2 fault
    logic [1:0] cause;
  } outc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // RV32 instance, short timeout
  logic       instr_valid, mem_ready, fault_clear;
  logic [6:0] opcode;
  logic [2:0] funct3, addr_lo;
  logic       instr_ready, memread, memwrite, regwrite, mem_unsigned, instr_done, fault;
  logic [1:0] mem_size, fault_cause;
  logic [3:0] byte_en;

  // RV64 instance, default timeout
  logic       instr_valid_w, mem_ready_w, fault_clear_w;
  logic [6:0] opcode_w;
  logic [2:0] funct3_w, addr_lo_w;
  logic       instr_ready_w, memread_w, memwrite_w, regwrite_w, mem_unsigned_w, instr_done_w, fault_w;
  logic [1:0] mem_size_w, fault_cause_w;
  logic [7:0] byte_en_w;

  multicycle_ctrl #(.XLEN(32), .WAIT_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct3(funct3), .addr_lo(addr_lo), .mem_ready(mem_ready),
    .fault_clear(fault_clear), .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .byte_en(byte_en),
    .instr_done(instr_done), .fault(fault), .fault_cause(fault_cause)
  );

  multicycle_ctrl #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid_w), .instr_ready(instr_ready_w),
    .opcode(opcode_w), .funct3(funct3_w), .addr_lo(addr_lo_w), .mem_ready(mem_ready_w),
    .fault_clear(fault_clear_w), .memread(memread_w), .memwrite(memwrite_w), .regwrite(regwrite_w),
    .mem_size(mem_size_w), .mem_unsigned(mem_unsigned_w), .byte_en(byte_en_w),
    .instr_done(instr_done_w), .fault(fault_w), .fault_cause(fault_cause_w)
  );

  int    checks = 0;
  int    errors = 0;
  outc_t exp_q[$];
  int    n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in IDLE, queue its expected outcome; returns in DECODE
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] a,
                       input logic [1:0] k, input logic [1:0] c);
    outc_t e;
    e.kind  = k;
    e.cause = c;
    exp_q.push_back(e);
    instr_valid = 1'b1;
    opcode      = op;
    funct3      = f3;
    addr_lo     = a;
    step();
    instr_valid = 1'b0;
    opcode      = 7'h7F;
    funct3      = 3'b111;
  endtask

  // Wait (bounded) for a retire or fault, then score it; returns at that negedge
  task automatic wait_outcome(input string tag, output int cyc);
    outc_t e, o;
    bit    hit;
    hit = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (instr_done || fault) begin
        hit = 1'b1;
        cyc = i;
        break;
      end
    end
    chk({tag, "_seen"}, 64'(hit), 64'd1);
    if (hit) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '1;
      o.kind  = fault ? 2'd2 : (regwrite ? 2'd0 : 2'd1);
      o.cause = fault_cause;
      chk({tag, "_sb"}, 64'(o), 64'(e));
    end
  endtask

  task automatic clear_fault(input string tag);
    step();
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    @(negedge clk);
    chk({tag, "_clr_ready"}, 64'(instr_ready), 64'd1);
    step();
  endtask

  task automatic issue64(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] a);
    instr_valid_w = 1'b1;
    opcode_w      = op;
    funct3_w      = f3;
    addr_lo_w     = a;
    step();
    instr_valid_w = 1'b0;
    opcode_w      = 7'h00;
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0; mem_ready = 1'b0; fault_clear = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; addr_lo = 3'd0;
    instr_valid_w = 1'b0; mem_ready_w = 1'b0; fault_clear_w = 1'b0;
    opcode_w = 7'd0; funct3_w = 3'd0; addr_lo_w = 3'd0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(instr_ready), 64'd1);
    chk("rst_outs", 64'({memread, memwrite, regwrite, mem_size, mem_unsigned, byte_en,
                         instr_done, fault, fault_cause}), 64'd0);
    step();

    // lw, aligned, immediate ready
    mem_ready = 1'b1;
    issue(OPC_LOAD, F3_W, 3'd0, 2'd0, CAUSE_NONE);
    @(negedge clk);
    chk("lw_c1_memread", 64'(memread), 64'd0);
    step();
    @(negedge clk);
    chk("lw_c2_memread", 64'(memread), 64'd1);
    chk("lw_c2_be", 64'(byte_en), 64'hF);
    chk("lw_c2_size", 64'(mem_size), 64'd2);
    chk("lw_c2_regwrite", 64'(regwrite), 64'd0);
    wait_outcome("lw", n);
    chk("lw_lat", 64'(n), 64'd1);
    chk("lw_c3_regwrite", 64'(regwrite), 64'd1);
    step();
    @(negedge clk);
    chk("lw_c4_ready", 64'(instr_ready), 64'd1);
    step();

    // sb at offset 3 with two wait cycles
    mem_ready = 1'b0;
    issue(OPC_STORE, F3_B, 3'd3, 2'd1, CAUSE_NONE);
    for (int k = 0; k < 2; k++) begin
      step();
      addr_lo = 3'd0;
      @(negedge clk);
      chk("sb_memwrite", 64'(memwrite), 64'd1);
      chk("sb_be", 64'(byte_en), 64'h8);
      chk("sb_busy", 64'({regwrite, instr_done}), 64'd0);
    end
    step();
    mem_ready = 1'b1;
    wait_outcome("sb", n);
    chk("sb_lat", 64'(n), 64'd1);
    chk("sb_last", 64'({memwrite, byte_en, regwrite}), 64'({1'b1, 4'h8, 1'b0}));
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sb_idle", 64'({instr_ready, memwrite}), 64'({1'b1, 1'b0}));
    step();

    // lh misaligned, then fault_clear together with instr_valid
    issue(OPC_LOAD, F3_H, 3'd1, 2'd2, CAUSE_MISALIGN);
    wait_outcome("lh", n);
    chk("lh_lat", 64'(n), 64'd2);
    chk("lh_memread", 64'(memread), 64'd0);
    step();
    fault_clear = 1'b1;
    instr_valid = 1'b1;
    opcode      = OPC_LOAD;
    funct3      = F3_W;
    @(negedge clk);
    chk("lh_held", 64'({fault, fault_cause}), 64'({1'b1, 2'd2}));
    step();
    fault_clear = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("lh_clr", 64'({instr_ready, fault, fault_cause}), 64'({1'b1, 1'b0, 2'd0}));
    step();

    // Illegal opcode, then ld on RV32
    issue(7'h7F, F3_B, 3'd0, 2'd2, CAUSE_ILLEGAL);
    wait_outcome("illop", n);
    clear_fault("illop");
    issue(OPC_LOAD, F3_D, 3'd0, 2'd2, CAUSE_ILLEGAL);
    wait_outcome("ld32", n);
    chk("ld32_memread", 64'(memread), 64'd0);
    clear_fault("ld32");

    // ALU ops write back in cycle 2
    issue(OPC_OP_IMM, F3_B, 3'd0, 2'd0, CAUSE_NONE);
    wait_outcome("opimm", n);
    chk("opimm_lat", 64'(n), 64'd2);
    step();
    issue(OPC_OP, F3_W, 3'd0, 2'd0, CAUSE_NONE);
    wait_outcome("op", n);
    chk("op_lat", 64'(n), 64'd2);
    chk("op_nomem", 64'({memread, memwrite}), 64'd0);
    step();

    // sw at addr_lo=4 (offset 0 on RV32), immediate ready
    mem_ready = 1'b1;
    issue(OPC_STORE, F3_W, 3'd4, 2'd1, CAUSE_NONE);
    wait_outcome("sw", n);
    chk("sw_lat", 64'(n), 64'd2);
    chk("sw_be", 64'(byte_en), 64'hF);
    step();
    mem_ready = 1'b0;

    // Timeout: MEM plus three WAIT cycles
    issue(OPC_LOAD, F3_W, 3'd0, 2'd2, CAUSE_TIMEOUT);
    wait_outcome("tmo", n);
    chk("tmo_lat", 64'(n), 64'd6);
    chk("tmo_memread", 64'(memread), 64'd0);
    clear_fault("tmo");

    // lbu with ready on the limit cycle: ready beats the timeout
    issue(OPC_LOAD, F3_BU, 3'd2, 2'd0, CAUSE_NONE);
    step();
    step();
    step();
    @(negedge clk);
    chk("lbu_wait", 64'({memread, byte_en, mem_unsigned, mem_size}),
        64'({1'b1, 4'b0100, 1'b1, 2'd0}));
    step();
    mem_ready = 1'b1;
    wait_outcome("lbu", n);
    chk("lbu_lat", 64'(n), 64'd2);
    step();
    mem_ready = 1'b0;

    // Reset while waiting drops memread without a clock edge
    issue(OPC_LOAD, F3_W, 3'd0, 2'd0, CAUSE_NONE);
    step();
    step();
    @(negedge clk);
    chk("rw_memread_on", 64'(memread), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rw_memread_off", 64'(memread), 64'd0);
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rw_ready", 64'(instr_ready), 64'd1);
    chk("rw_outs", 64'({memread, memwrite, regwrite, mem_size, mem_unsigned, byte_en,
                        instr_done, fault, fault_cause}), 64'd0);
    step();

    // RV64 instance: ld, lwu, misaligned sd, sh
    mem_ready_w = 1'b1;
    issue64(OPC_LOAD, F3_D, 3'd0);
    step();
    @(negedge clk);
    chk("ld64", 64'({memread_w, byte_en_w, mem_size_w}), 64'({1'b1, 8'hFF, 2'd3}));
    step();
    @(negedge clk);
    chk("ld64_wb", 64'({regwrite_w, instr_done_w}), 64'({1'b1, 1'b1}));
    step();
    issue64(OPC_LOAD, F3_WU, 3'd4);
    step();
    @(negedge clk);
    chk("lwu64", 64'({memread_w, byte_en_w, mem_size_w, mem_unsigned_w}),
        64'({1'b1, 8'hF0, 2'd2, 1'b1}));
    step();
    step();
    issue64(OPC_STORE, F3_D, 3'd4);
    step();
    @(negedge clk);
    chk("sd64_mis", 64'({fault_w, fault_cause_w, memwrite_w}), 64'({1'b1, 2'd2, 1'b0}));
    step();
    fault_clear_w = 1'b1;
    step();
    fault_clear_w = 1'b0;
    issue64(OPC_STORE, F3_H, 3'd6);
    @(negedge clk);
    chk("sh64_decode", 64'(memwrite_w), 64'd0);
    step();
    @(negedge clk);
    chk("sh64", 64'({memwrite_w, byte_en_w, instr_done_w}), 64'({1'b1, 8'hC0, 1'b1}));
    step();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
